huff_stream_out: RTL and testbench



---
 rtl/huff_pkg.sv | 10 +
 rtl/huff_skid2.sv | 39 +++
 rtl/huff_stream_out.sv | 96 +++++++++
 tb/tb_huff_stream_out.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// huff_pkg: shared constants, FSM encoding and byte-swap helper for the Huffman stream output block.
package huff_pkg;
    localparam logic [31:0] MAGIC_DEFAULT = 32'hD4C3B2A1;

    typedef enum logic [2:0] {IDLE, HDR_MAGIC, HDR_LEN, BODY, FLUSH, TRAILER} state_t;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/huff_skid2.sv
// huff_skid2: two-entry output skid buffer carrying a 32-bit word plus a last flag.
module huff_skid2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [1:0]  count
);
    logic [32:0] d0, d1;
    logic [1:0]  cnt;
    logic        push, pop;

    assign out_valid = cnt != 2'd0;
    assign pop = out_valid & out_ready;
    assign in_ready = (cnt != 2'd2) | pop;
    assign push = in_valid & in_ready;
    assign {out_last, out_data} = d0;
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            d0 <= pop ? (cnt == 2'd2 ? d1 : {in_last, in_data}) : (cnt == 2'd0 ? {in_last, in_data} : d0);
            // the tail slot is written only when the head stays occupied after this cycle
            if (push && cnt == (pop ? 2'd2 : 2'd1))
                d1 <= {in_last, in_data};
        end
    end
endmodule

// File: rtl/huff_stream_out.sv
// huff_stream_out: drains the encoded-word FIFO into the output stream, patching the length
// header and appending a byte-swapped word-count trailer.
module huff_stream_out
    import huff_pkg::*;
#(
    parameter logic [31:0] MAGIC_NUM   = MAGIC_DEFAULT,
    parameter bit          CHECK_MAGIC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_len,
    input  logic        encode_done,
    output logic        rd_encode,
    input  logic [31:0] encode_data,
    input  logic        encode_valid,
    input  logic        encode_empty,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        magic_err,
    output logic [31:0] word_cnt
);
    state_t      state, state_nx;
    logic        in_flight, rx, pop, skid_push, skid_ready, skid_valid, skid_last, trailer_push;
    logic [31:0] skid_data, push_data;
    logic [1:0]  rx_idx, occ;

    assign rx = encode_valid & in_flight;
    assign pop = skid_valid & out_ready;
    assign trailer_push = state == FLUSH && occ == 2'd0;
    assign skid_push = rx | trailer_push;
    assign push_data = trailer_push ? bswap(word_cnt) : (rx_idx == 2'd1 ? bswap(src_len) : encode_data);
    // a slot freed by this cycle's pop counts as room, which keeps one word per cycle flowing
    assign rd_encode = ~rst && (state inside {HDR_MAGIC, HDR_LEN, BODY}) && ~encode_empty && skid_ready
                       && ({1'b0, occ} + 3'(in_flight) - 3'(pop)) < 3'd2;

    assign out_valid = ~rst & skid_valid;
    assign out_last = ~rst & skid_valid & skid_last;
    assign out_data = rst ? 32'd0 : skid_data;
    assign busy = ~rst & (state != IDLE);
    assign done = ~rst & (state == TRAILER) & pop;

    huff_skid2 u_skid (
        .clk(clk), .rst(rst),
        .in_valid(skid_push), .in_ready(skid_ready), .in_data(push_data), .in_last(trailer_push),
        .out_valid(skid_valid), .out_ready(out_ready), .out_data(skid_data), .out_last(skid_last),
        .count(occ)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      state_nx = start ? HDR_MAGIC : IDLE;
            HDR_MAGIC: state_nx = pop ? HDR_LEN : HDR_MAGIC;
            HDR_LEN:   state_nx = pop ? BODY : HDR_LEN;
            BODY:      state_nx = (encode_done && encode_empty && !in_flight) ? FLUSH : BODY;
            FLUSH:     state_nx = occ == 2'd0 ? TRAILER : FLUSH;
            TRAILER:   state_nx = pop ? IDLE : TRAILER;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
            rx_idx <= 2'd0;
            word_cnt <= 32'd0;
            magic_err <= 1'b0;
        end else begin
            in_flight <= rd_encode;
            if (state == IDLE && start) begin
                word_cnt <= 32'd0;
                magic_err <= 1'b0;
                rx_idx <= 2'd0;
            end else begin
                if (pop)
                    word_cnt <= word_cnt + 32'd1;
                if (rx && rx_idx != 2'd2)
                    rx_idx <= rx_idx + 2'd1;
                if (rx && rx_idx == 2'd0 && CHECK_MAGIC && encode_data != MAGIC_NUM)
                    magic_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_huff_stream_out.sv
// tb_huff_stream_out: randomized frames through a FIFO model, checked against a queue-based
// expected-stream model.
module tb_huff_stream_out;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, encode_done = 1'b0;
    logic        rd_encode, encode_valid = 1'b0, encode_empty, out_valid, out_ready = 1'b1;
    logic        out_last, busy, done, magic_err;
    logic [31:0] src_len = 32'd0, encode_data = 32'd0, out_data, word_cnt;

    int tests = 0, fails = 0;
    logic [31:0] fmem [0:4095];
    int wr_ptr = 0, rd_ptr = 0;
    logic [31:0] got[$];
    logic        got_last[$];
    int done_cnt = 0, hold_err = 0, rds = 0, pops = 0, max_ahead = 0, rmode = 0, cyc = 0, underflow = 0;
    logic        prev_stall = 1'b0, prev_last = 1'b0, rd_s = 1'b0, rst_s = 1'b0;
    logic [31:0] prev_data = 32'd0;

    assign encode_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    huff_stream_out dut (
        .clk(clk), .rst(rst), .start(start), .src_len(src_len), .encode_done(encode_done),
        .rd_encode(rd_encode), .encode_data(encode_data), .encode_valid(encode_valid),
        .encode_empty(encode_empty), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .magic_err(magic_err), .word_cnt(word_cnt)
    );

    // FIFO model: data appears one cycle after a sampled read strobe
    always begin
        @(negedge clk);
        rd_s = rd_encode;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            rd_ptr = wr_ptr;
            encode_valid = 1'b0;
        end else if (rd_s && rd_ptr != wr_ptr) begin
            encode_data = fmem[rd_ptr];
            rd_ptr++;
            encode_valid = 1'b1;
        end else begin
            if (rd_s) underflow++;
            encode_valid = 1'b0;
            encode_data = $urandom;
        end
    end

    // sink: always ready, 1-0-0-1 pattern, or random
    always begin
        @(posedge clk);
        #1;
        cyc++;
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            rds = 0;
            pops = 0;
        end else begin
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) hold_err++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_last.push_back(out_last);
                if (!out_last) pops++;
            end
            if (rd_encode) rds++;
            if (rds - pops > max_ahead) max_ahead = rds - pops;
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] swap_ref(input logic [31:0] x);
        return ((x & 32'hFF) << 24) | ((x & 32'hFF00) << 8) | ((x >> 8) & 32'hFF00) | (x >> 24);
    endfunction

    function automatic int first_diff(input logic [31:0] a[$], input logic [31:0] b[$]);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : ((a.size() < b.size()) ? a.size() : b.size());
    endfunction

    task automatic build_exp(input logic [31:0] w[$], input logic [31:0] len, output logic [31:0] e[$]);
        e = {};
        foreach (w[i]) e.push_back(i == 1 ? swap_ref(len) : w[i]);
        e.push_back(swap_ref(w.size()));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fmem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_done(input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > n0) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic run_frame(input logic [31:0] w[$], input logic [31:0] len, input int mode,
                             input bit extra_start, output bit ok, output int lat, output int cycles);
        int n0;
        time t0;
        got.delete();
        got_last.delete();
        hold_err = 0;
        max_ahead = 0;
        rmode = mode;
        src_len = len;
        encode_done = 1'b1;
        foreach (w[i]) push_word(w[i]);
        n0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = $time;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        if (extra_start) begin
            start = 1'b1;
            tick;
            start = 1'b0;
        end
        wait_done(n0, ok);
        cycles = int'(($time - t0) / 10);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        tests++;
        if ({rd_encode, out_valid, out_last, busy, done, out_data} !== 38'd0)
            $display("FAIL reset_outputs got %h exp 0", {rd_encode, out_valid, out_last, busy, done, out_data});
        tests++;
        if (word_cnt !== 32'd0 || magic_err !== 1'b0)
            $display("FAIL reset_state got word_cnt %h magic_err %b exp 0 0", word_cnt, magic_err);
        if (word_cnt !== 32'd0 || magic_err !== 1'b0 ||
            {rd_encode, out_valid, out_last, busy, done, out_data} !== 38'd0) fails++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic(input string tag);
        logic [31:0] w[$], e[$];
        bit ok;
        int lat, cn, d, nl, n;
        w = {32'hD4C3B2A1, 32'h0};
        repeat (5) w.push_back($urandom);
        build_exp(w, 32'h00001234, e);
        n = done_cnt;
        run_frame(w, 32'h00001234, 0, 1'b0, ok, lat, cn);
        tests++;
        if (!ok) begin fails++; $display("FAIL %s_timeout got no done exp done", tag); end
        d = first_diff(got, e);
        tests++;
        if (d != -1) begin fails++; $display("FAIL %s_stream at %0d got size %0d exp size %0d", tag, d, got.size(), e.size()); end
        tests++;
        if (got.size() < 8 || got[1] !== 32'h34120000) begin fails++; $display("FAIL %s_len_word got %h exp 34120000", tag, got.size() > 1 ? got[1] : 32'hx); end
        tests++;
        if (got.size() < 8 || got[7] !== 32'h07000000) begin fails++; $display("FAIL %s_trailer got %h exp 07000000", tag, got.size() > 7 ? got[7] : 32'hx); end
        nl = 0;
        foreach (got_last[i]) nl += int'(got_last[i]);
        tests++;
        if (nl != 1 || got_last.size() == 0 || got_last[got_last.size() - 1] !== 1'b1) begin fails++; $display("FAIL %s_last got %0d lasts exp 1 on trailer", tag, nl); end
        tests++;
        if (word_cnt !== 32'd8) begin fails++; $display("FAIL %s_word_cnt got %0d exp 8", tag, word_cnt); end
        tests++;
        if (lat > 3) begin fails++; $display("FAIL %s_latency got %0d exp <=3", tag, lat); end
        tests++;
        if (cn > 14) begin fails++; $display("FAIL %s_rate got %0d cycles exp <=14", tag, cn); end
        repeat (3) tick;
        tests++;
        if (done_cnt - n != 1 || busy !== 1'b0) begin fails++; $display("FAIL %s_done got %0d pulses busy %b exp 1 0", tag, done_cnt - n, busy); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w[$], e[$], len;
        bit ok;
        int lat, cn, d;
        len = $urandom;
        w = {32'hD4C3B2A1, 32'h0};
        repeat (5) w.push_back($urandom);
        build_exp(w, len, e);
        run_frame(w, len, 1, 1'b1, ok, lat, cn);
        d = first_diff(got, e);
        tests++;
        if (!ok || d != -1) begin fails++; $display("FAIL bp_stream at %0d got size %0d exp size %0d", d, got.size(), e.size()); end
        tests++;
        if (hold_err != 0) begin fails++; $display("FAIL bp_hold got %0d violations exp 0", hold_err); end
        tests++;
        if (max_ahead > 2) begin fails++; $display("FAIL bp_read_ahead got %0d exp <=2", max_ahead); end
        tests++;
        if (word_cnt !== 32'd8) begin fails++; $display("FAIL bp_word_cnt got %0d exp 8", word_cnt); end
    endtask

    task automatic test_bad_magic;
        logic [31:0] w[$], e[$];
        bit ok;
        int lat, cn, d;
        w = {32'h12345678, 32'h0};
        repeat (5) w.push_back($urandom);
        build_exp(w, 32'h00001234, e);
        run_frame(w, 32'h00001234, 0, 1'b0, ok, lat, cn);
        tests++;
        if (magic_err !== 1'b1) begin fails++; $display("FAIL magic_set got %b exp 1", magic_err); end
        d = first_diff(got, e);
        tests++;
        if (!ok || d != -1) begin fails++; $display("FAIL magic_stream at %0d got size %0d exp 8", d, got.size()); end
        start = 1'b1;
        tick;
        start = 1'b0;
        tests++;
        if (magic_err !== 1'b0) begin fails++; $display("FAIL magic_clear got %b exp 0", magic_err); end
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_underrun;
        logic [31:0] w[$], e[$], len;
        bit ok;
        int n0, d;
        len = $urandom;
        w = {32'hD4C3B2A1, 32'h0};
        repeat (5) w.push_back($urandom);
        build_exp(w, len, e);
        got.delete();
        got_last.delete();
        rmode = 0;
        src_len = len;
        encode_done = 1'b0;
        for (int i = 0; i < 5; i++) push_word(w[i]);
        n0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (25) tick;
        tests++;
        if (got.size() != 5 || out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL underrun_stall got %0d words valid %b busy %b exp 5 0 1", got.size(), out_valid, busy);
        end
        push_word(w[5]);
        push_word(w[6]);
        tick;
        encode_done = 1'b1;
        wait_done(n0, ok);
        d = first_diff(got, e);
        tests++;
        if (!ok || d != -1) begin fails++; $display("FAIL underrun_stream at %0d got size %0d exp 8", d, got.size()); end
        tests++;
        if (got.size() < 8 || got[7] !== 32'h07000000) begin fails++; $display("FAIL underrun_trailer got %h exp 07000000", got.size() > 7 ? got[7] : 32'hx); end
    endtask

    task automatic test_reset_mid;
        int guard;
        rmode = 0;
        got.delete();
        got_last.delete();
        src_len = 32'h00001234;
        encode_done = 1'b1;
        push_word(32'hD4C3B2A1);
        push_word(32'h0);
        repeat (5) push_word($urandom);
        start = 1'b1;
        tick;
        start = 1'b0;
        guard = 0;
        while (got.size() < 4 && guard < 50) begin tick; guard++; end
        rst = 1'b1;
        #1;
        tests++;
        if ({rd_encode, out_valid, out_last, busy, done, out_data} !== 38'd0) begin
            fails++;
            $display("FAIL midrst_outputs got %h exp 0", {rd_encode, out_valid, out_last, busy, done, out_data});
        end
        tick;
        tests++;
        if (busy !== 1'b0 || word_cnt !== 32'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_idle got busy %b word_cnt %0d valid %b exp 0 0 0", busy, word_cnt, out_valid);
        end
        tick;
        rst = 1'b0;
        repeat (3) tick;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_restart got busy %b valid %b exp 0 0", busy, out_valid); end
        test_basic("post_rst");
    endtask

    task automatic test_header_only;
        logic [31:0] w[$], e[$], len;
        bit ok;
        int lat, cn, d;
        len = $urandom;
        w = {32'hD4C3B2A1, 32'h0};
        build_exp(w, len, e);
        run_frame(w, len, 0, 1'b0, ok, lat, cn);
        d = first_diff(got, e);
        tests++;
        if (!ok || d != -1) begin fails++; $display("FAIL hdr_only_stream at %0d got size %0d exp 3", d, got.size()); end
        tests++;
        if (got.size() != 3 || got[2] !== 32'h02000000 || word_cnt !== 32'd3) begin
            fails++;
            $display("FAIL hdr_only_trailer got %h cnt %0d exp 02000000 3", got.size() > 2 ? got[2] : 32'hx, word_cnt);
        end
    endtask

    task automatic test_random;
        logic [31:0] w[$], e[$], len;
        bit ok, bad;
        int lat, cn, d, nb;
        for (int f = 0; f < 8; f++) begin
            len = $urandom;
            bad = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 12);
            w = {bad ? 32'hD4C3B2A0 ^ $urandom_range(1, 255) : 32'hD4C3B2A1, 32'h0};
            repeat (nb) w.push_back($urandom);
            build_exp(w, len, e);
            run_frame(w, len, 2, 1'b0, ok, lat, cn);
            d = first_diff(got, e);
            tests++;
            if (!ok || d != -1) begin fails++; $display("FAIL rand%0d_stream at %0d got size %0d exp size %0d", f, d, got.size(), e.size()); end
            tests++;
            if (word_cnt !== 32'(nb + 3) || magic_err !== bad) begin
                fails++;
                $display("FAIL rand%0d_status got cnt %0d err %b exp %0d %b", f, word_cnt, magic_err, nb + 3, bad);
            end
            tests++;
            if (hold_err != 0 || max_ahead > 2 || underflow != 0) begin
                fails++;
                $display("FAIL rand%0d_flow got hold %0d ahead %0d underflow %0d exp 0 <=2 0", f, hold_err, max_ahead, underflow);
            end
            repeat ($urandom_range(0, 3)) tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic("basic");
        test_backpressure;
        test_bad_magic;
        test_underrun;
        test_reset_mid;
        test_header_only;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
